// File: rtl/butterfly_stage_pipe.sv
// Radix-2 add/sub butterfly stage with a two-register valid/ready pipeline.
// Each beat carries its own overflow policy. Overflowed beats are tracked by a sticky flag and a saturating counter.
`timescale 1ns/1ps
module butterfly_stage_pipe #(
  parameter int DW     = 12,
  parameter int N_PTS  = 8,
  parameter int STRIDE = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_PTS*DW-1:0]   IN_DATA,
  input  logic [1:0]            IN_MODE,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [N_PTS*DW-1:0]   OUT_DATA,
  output logic                  OUT_OVF,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  input  logic                  CLR_OVF,
  output logic                  OVF_STICKY,
  output logic [CNT_W-1:0]      OVF_CNT
);

  // Handshake: a beat moves across a boundary on any edge where the sender
  // holds valid and the receiver is ready. A stalled beat keeps its data
  // unchanged until it moves on.
  logic                r_s1_valid;
  logic [N_PTS*DW-1:0] r_s1_data;
  logic [1:0]          r_s1_mode;
  logic                r_out_valid;
  logic [N_PTS*DW-1:0] r_out_data;
  logic                r_out_ovf;
  logic                r_ovf_sticky;
  logic [CNT_W-1:0]    r_ovf_cnt;

  logic                w_s2_free;
  logic                w_in_ready;
  logic                w_ovf_hs;
  logic [N_PTS*DW-1:0] w_bf_data;
  logic [N_PTS-1:0]    w_pt_ovf;

  assign w_s2_free  = !r_out_valid || OUT_READY;
  assign w_in_ready = !r_s1_valid || w_s2_free;
  assign w_ovf_hs   = r_out_valid && OUT_READY && r_out_ovf;

  for (genvar k = 0; k < N_PTS; k++) begin : g_pt
    localparam int J     = k % (2 * STRIDE);
    localparam bit UPPER = (J >= STRIDE);
    localparam int IA    = UPPER ? k - STRIDE : k;
    localparam int IB    = UPPER ? k : k + STRIDE;

    logic signed [DW:0]   w_a;
    logic signed [DW:0]   w_b;
    logic signed [DW:0]   w_r;
    logic                 w_wrap_ovf;
    logic [DW-1:0]        w_pt;
    logic                 w_ovf;

    assign w_a = {r_s1_data[IA*DW+DW-1], r_s1_data[IA*DW +: DW]};
    assign w_b = {r_s1_data[IB*DW+DW-1], r_s1_data[IB*DW +: DW]};
    // The upper half of each pair holds first-of-pair minus second-of-pair.
    assign w_r = UPPER ? (w_a - w_b) : (w_a + w_b);
    assign w_wrap_ovf = w_r[DW] ^ w_r[DW-1];

    always_comb begin
      w_pt  = w_r[DW-1:0];
      w_ovf = 1'b0;
      case (r_s1_mode)
        2'b01: begin
          w_ovf = w_wrap_ovf;
          if (w_wrap_ovf)
            w_pt = w_r[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
        2'b10: begin
          w_pt = w_r[DW:1];
        end
        default: begin
          w_ovf = w_wrap_ovf;
        end
      endcase
    end

    assign w_bf_data[k*DW +: DW] = w_pt;
    assign w_pt_ovf[k]           = w_ovf;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_s1_mode    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ovf    <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_ovf_cnt    <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= IN_VALID;
        if (IN_VALID) begin
          r_s1_data <= IN_DATA;
          r_s1_mode <= IN_MODE;
        end
      end
      if (w_s2_free) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_bf_data;
          r_out_ovf  <= |w_pt_ovf;
        end
      end
      // Clear wins over an increment on the same edge.
      if (CLR_OVF) begin
        r_ovf_sticky <= 1'b0;
        r_ovf_cnt    <= '0;
      end else if (w_ovf_hs) begin
        r_ovf_sticky <= 1'b1;
        if (r_ovf_cnt != {CNT_W{1'b1}})
          r_ovf_cnt <= r_ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign IN_READY   = w_in_ready;
  assign OUT_DATA   = r_out_data;
  assign OUT_OVF    = r_out_ovf;
  assign OUT_VALID  = r_out_valid;
  assign OVF_STICKY = r_ovf_sticky;
  assign OVF_CNT    = r_ovf_cnt;

endmodule

// File: tb/tb_butterfly_stage_pipe.sv
// Directed bench for butterfly_stage_pipe: default stage, a STRIDE=1 stage and a CNT_W=2 stage.
`timescale 1ns/1ps
module tb_butterfly_stage_pipe;
  localparam int DW = 12;
  localparam int NP = 8;
  localparam int W  = NP * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_mode = 2'b00;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] out_data;
  logic         out_ovf, out_valid;
  logic         out_ready = 1'b1, clr_ovf = 1'b0, ovf_sticky;
  logic [15:0]  ovf_cnt;

  // STRIDE=1 instance
  logic [W-1:0] s_in_data = '0;
  logic [1:0]   s_in_mode = 2'b00;
  logic         s_in_valid = 1'b0, s_in_ready;
  logic [W-1:0] s_out_data;
  logic         s_out_ovf, s_out_valid;
  logic         s_out_ready = 1'b1, s_clr = 1'b0, s_sticky;
  logic [15:0]  s_cnt;

  // CNT_W=2 instance
  logic [W-1:0] c_in_data = '0;
  logic [1:0]   c_in_mode = 2'b00;
  logic         c_in_valid = 1'b0, c_in_ready;
  logic [W-1:0] c_out_data;
  logic         c_out_ovf, c_out_valid;
  logic         c_out_ready = 1'b1, c_clr = 1'b0, c_sticky;
  logic [1:0]   c_cnt;

  butterfly_stage_pipe #(.DW(DW), .N_PTS(NP), .STRIDE(4), .CNT_W(16)) dut (
    .CLK(clk), .RESET(rst_n), .IN_DATA(in_data), .IN_MODE(in_mode),
    .IN_VALID(in_valid), .IN_READY(in_ready), .OUT_DATA(out_data),
    .OUT_OVF(out_ovf), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .CLR_OVF(clr_ovf), .OVF_STICKY(ovf_sticky), .OVF_CNT(ovf_cnt));

  butterfly_stage_pipe #(.DW(DW), .N_PTS(NP), .STRIDE(1), .CNT_W(16)) dut_s (
    .CLK(clk), .RESET(rst_n), .IN_DATA(s_in_data), .IN_MODE(s_in_mode),
    .IN_VALID(s_in_valid), .IN_READY(s_in_ready), .OUT_DATA(s_out_data),
    .OUT_OVF(s_out_ovf), .OUT_VALID(s_out_valid), .OUT_READY(s_out_ready),
    .CLR_OVF(s_clr), .OVF_STICKY(s_sticky), .OVF_CNT(s_cnt));

  butterfly_stage_pipe #(.DW(DW), .N_PTS(NP), .STRIDE(4), .CNT_W(2)) dut_c (
    .CLK(clk), .RESET(rst_n), .IN_DATA(c_in_data), .IN_MODE(c_in_mode),
    .IN_VALID(c_in_valid), .IN_READY(c_in_ready), .OUT_DATA(c_out_data),
    .OUT_OVF(c_out_ovf), .OUT_VALID(c_out_valid), .OUT_READY(c_out_ready),
    .CLR_OVF(c_clr), .OVF_STICKY(c_sticky), .OVF_CNT(c_cnt));

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pt(input logic [W-1:0] d, input int k);
    logic signed [DW-1:0] v;
    v = d[k*DW +: DW];
    return int'(v);
  endfunction

  function automatic logic [W-1:0] pk(input int x[NP]);
    logic [W-1:0] r;
    logic [31:0]  t;
    r = '0;
    for (int k = 0; k < NP; k++) begin
      t = x[k];
      r[k*DW +: DW] = t[DW-1:0];
    end
    return r;
  endfunction

  // Drives one beat; returns at the negedge where its result should be visible.
  task automatic send_beat(input logic [W-1:0] d, input logic [1:0] m);
    @(negedge clk);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_not_early", out_valid, 0);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x[NP];
    int ovf_beat[NP];
    int bx0[6], bx4[6], eo0[6], eo4[6], eovf[6];
    int sent, rcvd;
    bit stalled_seen, held_valid;
    logic [W:0] held;

    // reset
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_cnt", ovf_cnt, 0);
    check("rst_sticky", ovf_sticky, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // basic wrap beat
    x = '{100, -7, 0, 0, 50, 3, 0, 0};
    send_beat(pk(x), 2'b00);
    check("basic_ovf", out_ovf, 0);
    check("basic_out0", pt(out_data, 0), 150);
    check("basic_out1", pt(out_data, 1), -4);
    check("basic_out4", pt(out_data, 4), 50);
    check("basic_out5", pt(out_data, 5), -10);

    // overflow policies
    ovf_beat = '{2000, -2048, 0, 0, 100, 1, 0, 0};
    send_beat(pk(ovf_beat), 2'b00);
    check("wrap_out0", pt(out_data, 0), -1996);
    check("wrap_out5", pt(out_data, 5), 2047);
    check("wrap_out4", pt(out_data, 4), 1900);
    check("wrap_ovf", out_ovf, 1);
    send_beat(pk(ovf_beat), 2'b01);
    check("sat_out0", pt(out_data, 0), 2047);
    check("sat_out5", pt(out_data, 5), -2048);
    check("sat_out1", pt(out_data, 1), -2047);
    check("sat_ovf", out_ovf, 1);
    send_beat(pk(ovf_beat), 2'b10);
    check("halve_out0", pt(out_data, 0), 1050);
    check("halve_out5", pt(out_data, 5), -1025);
    check("halve_out4", pt(out_data, 4), 950);
    check("halve_out1", pt(out_data, 1), -1024);
    check("halve_ovf", out_ovf, 0);
    send_beat(pk(ovf_beat), 2'b11);
    check("rsv_out0", pt(out_data, 0), -1996);
    check("rsv_out5", pt(out_data, 5), 2047);
    check("rsv_ovf", out_ovf, 1);
    @(negedge clk);
    check("stats_cnt3", ovf_cnt, 3);
    check("stats_sticky", ovf_sticky, 1);
    check("stats_drained", out_valid, 0);

    // clear coincident with a 4th overflowing handshake
    send_beat(pk(ovf_beat), 2'b00);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_cnt", ovf_cnt, 0);
    check("clr_sticky", ovf_sticky, 0);

    // backpressure: 6 back-to-back beats, output stalled 4 cycles
    bx0  = '{1, 2, 2000, -5, 2047, 10};
    bx4  = '{1, 3, 100, 7, 1, -20};
    eo0  = '{2, 5, -1996, 2, -2048, -10};
    eo4  = '{0, -1, 1900, -12, 2046, 30};
    eovf = '{0, 0, 1, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      x = '{eo0[i], 0, 0, 0, eo4[i], 0, 0, 0};
      exp_q.push_back({eovf[i][0], pk(x)});
    end
    sent = 0; rcvd = 0; stalled_seen = 0; held_valid = 0; held = '0;
    for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 7);
      if (sent < 6) begin
        x = '{bx0[sent], 0, 0, 0, bx4[sent], 0, 0, 0};
        in_data  = pk(x);
        in_mode  = 2'b00;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) stalled_seen = 1;
      if (out_valid && !out_ready) begin
        if (held_valid) check("bp_hold", {out_ovf, out_data}, held);
        held = {out_ovf, out_data};
        held_valid = 1;
      end else begin
        held_valid = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_extra_beat", out_valid, 0);
        else check("bp_beat", {out_ovf, out_data}, exp_q.pop_front());
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_rcvd", rcvd, 6);
    check("bp_in_ready_dropped", stalled_seen, 1);
    check("bp_cnt", ovf_cnt, 2);

    // STRIDE=1 instance
    x = '{1, 2, 3, 4, 5, 6, 7, 8};
    @(negedge clk);
    s_in_data  = pk(x);
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    check("s1_valid", s_out_valid, 1);
    x = '{3, -1, 7, -1, 11, -1, 15, -1};
    for (int k = 0; k < NP; k++) check($sformatf("s1_out%0d", k), pt(s_out_data, k), x[k]);
    check("s1_ovf", s_out_ovf, 0);

    // CNT_W=2 instance saturates
    @(negedge clk);
    c_in_data  = pk(ovf_beat);
    c_in_valid = 1'b1;
    repeat (5) @(negedge clk);
    c_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("cnt2_sat", c_cnt, 3);
    check("cnt2_sticky", c_sticky, 1);

    // asynchronous reset mid-stream with a held output beat
    out_ready = 1'b0;
    @(negedge clk);
    in_data  = pk(ovf_beat);
    in_mode  = 2'b00;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_cnt", ovf_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 0);
    check("mid_cnt", ovf_cnt, 0);
    check("mid_sticky", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_in_ready", in_ready, 1);
    check("mid_valid_after", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
